// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Shares the CPU's single Avalon-MM bus between the instruction-fetch
//   master (i_*) and the load/store data master (d_*). One owner at a time;
//   the grant is held until the owner's transfer completes (request high
//   with waitrequest low at the clock edge).
//
// Ports
//   clk, reset         : clock, asynchronous active-low reset
//   i_address/i_read   : fetch request;  i_waitrequest/i_readdata back to fetch
//   d_address/d_read/d_write/d_writedata/d_byteenable : data request
//   d_waitrequest/d_readdata : back to data master
//   address/read/write/writedata/byteenable : to bus
//   waitrequest/readdata : from bus
//   owner              : 0 = none, 1 = fetch, 2 = data
module mips_bus_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last_d;       // 1: data port was the most recent completer
    logic   w_last_d_next;
    logic   w_i_req;
    logic   w_d_req;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    assign owner      = r_state;
    assign i_readdata = readdata;
    assign d_readdata = readdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_last_d <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_last_d <= w_last_d_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_last_d_next = r_last_d;
        address       = '0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        byteenable    = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    if (DATA_PRIORITY)
                        w_next = OWN_D;
                    else
                        w_next = r_last_d ? OWN_I : OWN_D;
                end else if (w_i_req) begin
                    w_next = OWN_I;
                end else if (w_d_req) begin
                    w_next = OWN_D;
                end
            end

            OWN_I: begin
                address       = i_address;
                read          = i_read;
                byteenable    = '1;
                i_waitrequest = waitrequest;
                if (!w_i_req) begin
                    // Request withdrawn mid-transfer: release without
                    // crediting the fetch port in the round-robin history.
                    w_next = IDLE;
                end else if (!waitrequest) begin
                    w_last_d_next = 1'b0;
                    w_next        = w_d_req ? OWN_D : IDLE;
                end
            end

            OWN_D: begin
                address       = d_address;
                read          = d_read & ~d_write;  // write wins if both set
                write         = d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
                if (!w_d_req) begin
                    w_next = IDLE;
                end else if (!waitrequest) begin
                    w_last_d_next = 1'b1;
                    w_next        = w_i_req ? OWN_I : IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
